// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory, and decode.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] out_next_pc;
    logic                out_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instruction, out_next_pc, out_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instruction, out_next_pc, out_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack memory FSM, one-entry skid buffer, redirect squash.
// Define FETCH_PERF_CNT_EN to add the saturating bubble_count_o performance counter.
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
    parameter logic [31:0]         NOP_WORD = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   bubble_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_ONE;
    endfunction

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                req_q, req_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
    logic                valid_q, valid_d;
    logic                skid_valid_q, skid_valid_d;
    logic [31:0]         skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0] skid_next_pc_q, skid_next_pc_d;
    logic [PC_WIDTH-1:0] addr_inc_s;
    logic                valid_zero_s;
    logic                bubble_s;

    assign addr_inc_s = pc_inc(req_addr_q);

    // Next-state logic: FSM transitions, output register and skid buffer updates.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_addr_d     = req_addr_q;
        instr_d        = instr_q;
        next_pc_d      = next_pc_q;
        valid_d        = valid_q;
        skid_valid_d   = skid_valid_q;
        skid_instr_d   = skid_instr_q;
        skid_next_pc_d = skid_next_pc_q;
        valid_zero_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (bus.redirect) begin
                    pc_d         = bus.redirect_pc;
                    req_addr_d   = bus.redirect_pc;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    valid_zero_s = 1'b1;
                end else begin
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    pc_d         = bus.redirect_pc;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    valid_zero_s = 1'b1;
                    // Address may only change once the pending request is acked.
                    if (bus.imem_ack) begin
                        req_addr_d = bus.redirect_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    pc_d = addr_inc_s;
                    if (!bus.stall) begin
                        instr_d    = bus.imem_rdata;
                        next_pc_d  = addr_inc_s;
                        valid_d    = 1'b1;
                        req_addr_d = addr_inc_s;
                    end else begin
                        skid_instr_d   = bus.imem_rdata;
                        skid_next_pc_d = addr_inc_s;
                        skid_valid_d   = 1'b1;
                        state_d        = S_HOLD;
                    end
                end else if (!bus.stall) begin
                    valid_d      = 1'b0;
                    valid_zero_s = 1'b1;
                end else begin
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d         = bus.redirect_pc;
                    req_addr_d   = bus.redirect_pc;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    valid_zero_s = 1'b1;
                    state_d      = S_REQ;
                end else if (!bus.stall) begin
                    instr_d      = skid_instr_q;
                    next_pc_d    = skid_next_pc_q;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    req_addr_d   = pc_q;
                    state_d      = S_REQ;
                end else begin
                end
            end
            S_DRAIN: begin
                valid_d      = 1'b0;
                valid_zero_s = 1'b1;
                if (bus.redirect) begin
                    pc_d         = bus.redirect_pc;
                    skid_valid_d = 1'b0;
                end else if (bus.imem_ack) begin
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end else begin
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Decode sees NOP_WORD whenever the slot is empty.
        if (!valid_d) begin
            instr_d = NOP_WORD;
        end else begin
        end
    end

    assign req_d    = (state_d == S_REQ) || (state_d == S_DRAIN);
    assign bubble_s = valid_zero_s && !bus.stall;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            req_addr_q     <= RESET_PC;
            req_q          <= 1'b0;
            instr_q        <= NOP_WORD;
            next_pc_q      <= PC_ZERO;
            valid_q        <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_instr_q   <= NOP_WORD;
            skid_next_pc_q <= PC_ZERO;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            req_q          <= req_d;
            instr_q        <= instr_d;
            next_pc_q      <= next_pc_d;
            valid_q        <= valid_d;
            skid_valid_q   <= skid_valid_d;
            skid_instr_q   <= skid_instr_d;
            skid_next_pc_q <= skid_next_pc_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = req_addr_q;
    assign bus.instruction = instr_q;
    assign bus.out_next_pc = next_pc_q;
    assign bus.out_valid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Saturating count of cycles in which decode is handed an empty slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_cnt_q <= 32'd0;
        end else if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_q <= bubble_cnt_q;
        end
    end

    assign bubble_count_o = bubble_cnt_q;
`else
    logic unused_bubble_s;
    assign unused_bubble_s = bubble_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each row gives one cycle of inputs
// and the hand-computed register values expected after that clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] npc;
        logic [31:0] bub;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] bubble_count;
    int          checks;
    int          failures;
    int          cur_row;
    vec_t        vecs[32];

    fetch_stage_if #(.PC_WIDTH(32)) bus ();

    fetch_stage #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(NOP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .bubble_count_o(bubble_count)
`endif
    );

`ifndef FETCH_PERF_CNT_EN
    assign bubble_count = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic a,
                                input logic q, input logic [31:0] ad, input logic v,
                                input logic [31:0] np, input logic [31:0] b);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.ack = a;
        t.req = q; t.addr = ad; t.valid = v; t.npc = np; t.bub = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, cur_row, act, exp);
        end
    endtask

    task automatic check_outputs(input logic req, input logic [31:0] addr, input logic valid,
                                 input logic [31:0] npc, input logic [31:0] bub);
        logic [31:0] exp_instr;
        exp_instr = valid ? memf(npc - 32'd1) : NOP;
        check("imem_req",    {31'd0, bus.imem_req},  {31'd0, req});
        check("imem_addr",   bus.imem_addr,          addr);
        check("out_valid",   {31'd0, bus.out_valid}, {31'd0, valid});
        check("out_next_pc", bus.out_next_pc,        npc);
        check("instruction", bus.instruction,        exp_instr);
`ifdef FETCH_PERF_CNT_EN
        check("bubble_count", bubble_count, bub);
`else
        if (bub === 32'hFFFF_FFFF) $display("note: bubble %0d", bub);
`endif
    endtask

    // Called at a negedge: drive one row, clock it, compare, return at the next negedge.
    task automatic apply_row(input int idx);
        vec_t v;
        v = vecs[idx];
        cur_row = idx;
        bus.stall       = v.stall;
        bus.redirect    = v.redir;
        bus.redirect_pc = v.rpc;
        bus.imem_ack    = v.ack;
        bus.imem_rdata  = memf(bus.imem_addr);
        @(posedge clk);
        #1;
        check_outputs(v.req, v.addr, v.valid, v.npc, v.bub);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur_row  = -1;

        //                stall redir rpc           ack   req  addr          valid npc       bub
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,  32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        1'b1, 32'h1,  32'd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2,        1'b1, 32'h2,  32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3,        1'b1, 32'h3,  32'd0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3,        1'b0, 32'h3,  32'd1);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3,        1'b0, 32'h3,  32'd2);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h4,  32'd2);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b0, 32'h4,  32'd3);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b0, 32'h4,  32'd4);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h5,        1'b1, 32'h5,  32'd4);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h5,        1'b1, 32'h5,  32'd4);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h5,        1'b1, 32'h5,  32'd4);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h5,        1'b1, 32'h5,  32'd4);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h6,        1'b1, 32'h6,  32'd4);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h7,        1'b1, 32'h7,  32'd4);
        vecs[15] = mk(1'b0, 1'b1, 32'h40,       1'b0, 1'b1, 32'h7,        1'b0, 32'h7,  32'd5);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h7,        1'b0, 32'h7,  32'd6);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       1'b0, 32'h7,  32'd7);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h41,       1'b1, 32'h41, 32'd7);
        vecs[19] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h41,       1'b1, 32'h41, 32'd7);
        vecs[20] = mk(1'b1, 1'b1, 32'h80,       1'b0, 1'b1, 32'h80,       1'b0, 32'h41, 32'd7);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h81,       1'b1, 32'h81, 32'd7);
        vecs[22] = mk(1'b0, 1'b1, 32'h10,       1'b1, 1'b1, 32'h10,       1'b0, 32'h81, 32'd8);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h11,       1'b1, 32'h11, 32'd8);
        vecs[24] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11,       1'b1, 32'h11, 32'd8);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h12,       1'b1, 32'h12, 32'd8);
        vecs[26] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h12, 32'd9);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'h0,  32'd9);
        vecs[28] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        1'b1, 32'h1,  32'd9);
        vecs[29] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1,        1'b0, 32'h1,  32'd10);
        // Rows 30-31 follow the mid-wait reset: restart at RESET_PC.
        vecs[30] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,  32'd0);
        vecs[31] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1,        1'b1, 32'h1,  32'd0);

        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        rst_n           = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs(1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            apply_row(i);
        end

        // Asynchronous reset while a request is waiting for its ack.
        cur_row          = 100;
        bus.imem_ack     = 1'b0;
        bus.stall        = 1'b0;
        bus.redirect     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 30; i < 32; i++) begin
            apply_row(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage. Holds the PC and fetches instructions over a req/ack instruction-memory interface that tolerates wait states. Presents a registered instruction, the incremented PC (next_pc) and a valid bit to decode. Honours decode back-pressure (stall) and redirects from branch/jump resolution.

Parameters:
PC_WIDTH, 32, width of PC and of all address/next_pc ports
RESET_PC, 0, PC value loaded at reset
NOP_WORD, 32'h0000_0000, instruction value driven while out_valid=0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  decode cannot accept; output registers hold
redirect  input  1  branch/jump taken; squash and refetch
redirect_pc  input  PC_WIDTH  target PC, valid when redirect=1
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  PC_WIDTH  word address, stable while imem_req=1
imem_ack  input  1  imem_rdata valid this cycle; may arrive in the request cycle
imem_rdata  input  32  fetched instruction word
instruction  output  32  instruction to decode
out_next_pc  output  PC_WIDTH  address of the fetched instruction + 1
out_valid  output  1  instruction/out_next_pc valid

Behaviour:
- Word addressing: the PC increments by 1. Arithmetic wraps modulo 2^PC_WIDTH.
- Reset (rst=0, asynchronous) sets: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, instruction=NOP_WORD, out_next_pc=0, out_valid=0, skid buffer empty. imem_req is 0 during reset.
- FSM states:
  - IDLE: entered after reset; advances to REQ on the next cycle.
  - REQ: imem_req=1, imem_addr=req_addr.
  - HOLD: a word is fetched but decode is stalled; imem_req=0.
  - DRAIN: a stale request is outstanding; imem_req=1 with the old address, and its data will be discarded.
- REQ with imem_ack=1 and stall=0:
  - instruction<=imem_rdata, out_next_pc<=req_addr+1, out_valid<=1.
  - pc and req_addr<=req_addr+1.
  - Stay in REQ. This gives 1 instruction/cycle with zero-wait memory.
- REQ with imem_ack=1 and stall=1: capture imem_rdata and req_addr+1 into the skid buffer; go to HOLD.
- REQ with imem_ack=0: address stays stable. If stall=0, out_valid<=0 (bubble). If stall=1, the outputs hold.
- HOLD with stall=0: move the skid buffer to the outputs, set out_valid<=1, set req_addr<=pc, go to REQ. HOLD with stall=1: no change.
- stall=1 in any state: instruction, out_next_pc and out_valid hold their values.
- Redirect has the highest priority. On the cycle redirect=1:
  - out_valid<=0, skid buffer cleared, pc<=redirect_pc.
  - REQ with imem_ack=1: discard data, req_addr<=redirect_pc, stay in REQ.
  - REQ with imem_ack=0: go to DRAIN; req_addr is held because the memory contract forbids changing the address before ack.
  - HOLD or IDLE: req_addr<=redirect_pc, go to REQ.
  - DRAIN: update pc only, stay in DRAIN.
- DRAIN with imem_ack=1: discard data, set req_addr<=pc, go to REQ. out_valid stays 0 throughout DRAIN.
- Simultaneous redirect and stall: redirect wins and out_valid<=0. The decode stage treats stall as irrelevant for a squashed slot.
- Latency: from imem_ack (with stall=0) to out_valid=1 is 1 clock. From redirect to the first request at the target is 1 clock, or ack+1 if in DRAIN.
- The skid buffer is a single entry, so at most one instruction is in flight beyond the outputs.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, the block adds output bubble_count[31:0]:
- Reset value is 0.
- Increments on every cycle where out_valid is written 0 while stall=0, including redirect squashes and DRAIN cycles.
- Saturates at 32'hFFFF_FFFF.
When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
1. Zero-wait memory (ack tied to req), RESET_PC=0, no stall -> imem_addr 0,1,2,3 on consecutive cycles; out_valid=1 from cycle 2; out_next_pc 1,2,3.
2. Memory with 2 wait states -> each instruction is valid one cycle after its ack; two bubbles (out_valid=0) between instructions; imem_addr is stable while imem_req=1.
3. Stall asserted on the ack cycle of addr 5 for 3 cycles -> outputs hold the addr-4 instruction; state HOLD with imem_req=0; after the stall drops, the addr-5 word appears with out_next_pc=6 and the next request is at addr 6.
4. Redirect to 0x40 while the request to addr 7 is pending (ack 2 cycles later) -> imem_addr stays 7 until ack; the data is discarded (out_valid=0); the next request is at 0x40 and its word appears with out_next_pc=0x41.
5. Redirect to 0x80 with stall=1 while in HOLD -> out_valid=0 next cycle, skid buffer dropped, request to 0x80 issued.
6. Assert rst low mid-wait-state -> outputs, imem_req, and bubble_count (if FETCH_PERF_CNT_EN) clear asynchronously; after release, fetch restarts at RESET_PC.
